// File: rtl/fma_line_cache.sv
// Line-organised operand cache for a bank of FMAs: decodes memory instructions,
// stages immediates word by word, stores buffer lines and streams lines out.
module fma_line_cache #(
  parameter int FMA_COUNT         = 2,
  parameter int WORD_WIDTH        = 16,
  parameter int DEPTH             = 375,
  parameter int BRAM_LATENCY      = 2,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LINE_WIDTH        = FMA_COUNT * 3 * WORD_WIDTH,
  parameter int WORDS             = FMA_COUNT * 3,
  parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic [LINE_WIDTH-1:0]        buffer_line_in,
  input  logic                         buffer_valid_in,
  output logic                         buffer_ready_out,
  output logic [LINE_WIDTH-1:0]        abc_out,
  output logic                         abc_valid_out,
  input  logic                         abc_ready_in,
  output logic [ADDR_WIDTH-1:0]        addr_out,
  output logic                         idle_out,
  output logic [2:0]                   error_out
);

  // Handshakes: a transfer happens on a rising clk_in edge where valid and
  // ready are both high; a valid source holds its data stable until then.

  localparam int CNT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_FLUSH  = 4'b1110;
  localparam logic [3:0] OP_LOADB  = 4'b1010;
  localparam logic [3:0] OP_WRITEB = 4'b1100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUF  = 2'd1,
    READ_WAIT = 2'd2,
    OUT_HOLD  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    inc_pend_q;
  logic [WORD_WIDTH-1:0]   stage_q [WORDS];
  logic [WORDS-1:0]        mask_q;
  logic [LINE_WIDTH-1:0]   mem [DEPTH];
  logic [LINE_WIDTH-1:0]   rd_pipe [BRAM_LATENCY];

  logic [3:0]              opcode;
  logic [3:0]              rega;
  logic [15:0]             imm;
  logic                    inc_flag;
  logic                    rega_ok;
  logic                    imm_ok;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [LINE_WIDTH-1:0]   staged_line;
  logic                    wr_en;
  logic [LINE_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic                    unused_instr_bits;

  assign opcode   = instr_in[31:28];
  assign rega     = instr_in[27:24];
  assign imm      = instr_in[23:8];
  assign inc_flag = instr_in[4];
  assign unused_instr_bits = ^{instr_in[7:5], instr_in[3:0]};

  assign rega_ok  = 32'(rega) < WORDS;
  assign imm_ok   = 32'(imm) < DEPTH;
  assign addr_inc = (addr_out == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_out + 1'b1;

  // Unstaged words read as zero so a partial FLUSH never leaks stale data.
  always_comb begin
    staged_line = '0;
    for (int k = 0; k < WORDS; k++) begin
      staged_line[LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = mask_q[k] ? stage_q[k] : '0;
    end
  end

  assign wr_en = !rst_in &&
                 (((state_q == IDLE) && instr_valid_in && (opcode == OP_FLUSH)) ||
                  ((state_q == WAIT_BUF) && buffer_valid_in));
  assign wr_data = (state_q == WAIT_BUF) ? buffer_line_in : staged_line;
  assign rd_en = !rst_in && (state_q == IDLE) && instr_valid_in && (opcode == OP_WRITEB);

  // Block RAM: no reset so contents survive rst_in; read data emerges from the
  // last pipeline stage BRAM_LATENCY edges after the read is issued.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[addr_out] <= wr_data;
    end
    if (rd_en) begin
      rd_pipe[0] <= mem[addr_out];
    end
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= IDLE;
      instr_ready_out  <= 1'b1;
      idle_out         <= 1'b1;
      buffer_ready_out <= 1'b0;
      abc_valid_out    <= 1'b0;
      abc_out          <= '0;
      addr_out         <= '0;
      error_out        <= '0;
      cnt_q            <= '0;
      inc_pend_q       <= 1'b0;
      mask_q           <= '0;
      for (int k = 0; k < WORDS; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid_in) begin
            case (opcode)
              OP_NOP: ;
              OP_SMA: begin
                if (imm_ok) addr_out <= imm[ADDR_WIDTH-1:0];
                else        error_out[2] <= 1'b1;
              end
              OP_LOADI: begin
                if (rega_ok) begin
                  for (int k = 0; k < WORDS; k++) begin
                    if (32'(rega) == k) begin
                      stage_q[k] <= imm[WORD_WIDTH-1:0];
                      mask_q[k]  <= 1'b1;
                    end
                  end
                end else begin
                  error_out[0] <= 1'b1;
                end
              end
              OP_FLUSH: begin
                mask_q <= '0;
                for (int k = 0; k < WORDS; k++) begin
                  stage_q[k] <= '0;
                end
                if (inc_flag) addr_out <= addr_inc;
              end
              OP_LOADB: begin
                inc_pend_q       <= inc_flag;
                state_q          <= WAIT_BUF;
                instr_ready_out  <= 1'b0;
                idle_out         <= 1'b0;
                buffer_ready_out <= 1'b1;
              end
              OP_WRITEB: begin
                if (inc_flag) addr_out <= addr_inc;
                cnt_q           <= '0;
                state_q         <= READ_WAIT;
                instr_ready_out <= 1'b0;
                idle_out        <= 1'b0;
              end
              default: error_out[1] <= 1'b1;
            endcase
          end
        end
        WAIT_BUF: begin
          if (buffer_valid_in) begin
            if (inc_pend_q) addr_out <= addr_inc;
            state_q          <= IDLE;
            instr_ready_out  <= 1'b1;
            idle_out         <= 1'b1;
            buffer_ready_out <= 1'b0;
          end
        end
        READ_WAIT: begin
          if (cnt_q == CNT_W'(BRAM_LATENCY - 1)) begin
            abc_out       <= rd_pipe[BRAM_LATENCY-1];
            abc_valid_out <= 1'b1;
            state_q       <= OUT_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUT_HOLD: begin
          if (abc_ready_in) begin
            abc_valid_out   <= 1'b0;
            state_q         <= IDLE;
            instr_ready_out <= 1'b1;
            idle_out        <= 1'b1;
          end
        end
        default: begin
          state_q         <= IDLE;
          instr_ready_out <= 1'b1;
          idle_out        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fma_line_cache.sv
// Directed and randomized checks of fma_line_cache against a line-level
// model of the cache contents, staging words, address and error flags.
module tb_fma_line_cache;

  localparam int FMA_COUNT    = 2;
  localparam int WORD_WIDTH   = 16;
  localparam int DEPTH        = 375;
  localparam int BRAM_LATENCY = 2;
  localparam int IW           = 32;
  localparam int WORDS        = FMA_COUNT * 3;
  localparam int LW           = WORDS * WORD_WIDTH;
  localparam int AW           = $clog2(DEPTH);

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_FLUSH  = 4'b1110;
  localparam logic [3:0] OP_LOADB  = 4'b1010;
  localparam logic [3:0] OP_WRITEB = 4'b1100;

  // clock / reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in;
  logic [IW-1:0] instr_in;
  logic          instr_valid_in;
  logic          instr_ready_out;
  logic [LW-1:0] buffer_line_in;
  logic          buffer_valid_in;
  logic          buffer_ready_out;
  logic [LW-1:0] abc_out;
  logic          abc_valid_out;
  logic          abc_ready_in;
  logic [AW-1:0] addr_out;
  logic          idle_out;
  logic [2:0]    error_out;

  fma_line_cache #(
    .FMA_COUNT(FMA_COUNT), .WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH),
    .BRAM_LATENCY(BRAM_LATENCY), .INSTRUCTION_WIDTH(IW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .instr_in(instr_in), .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .buffer_line_in(buffer_line_in), .buffer_valid_in(buffer_valid_in),
    .buffer_ready_out(buffer_ready_out),
    .abc_out(abc_out), .abc_valid_out(abc_valid_out), .abc_ready_in(abc_ready_in),
    .addr_out(addr_out), .idle_out(idle_out), .error_out(error_out)
  );

  // reference model
  logic [LW-1:0]         ref_mem [DEPTH];
  bit                    ref_written [DEPTH];
  logic [WORD_WIDTH-1:0] ref_stage [WORDS];
  int                    ref_addr;
  logic [2:0]            ref_err;
  logic [LW-1:0]         exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] ra,
                                       input logic [15:0] imm, input logic inc);
    logic [2:0] junk_hi;
    logic [3:0] junk_lo;
    junk_hi = 3'($urandom_range(0, 7));
    junk_lo = 4'($urandom_range(0, 15));
    return {op, ra, imm, junk_hi, inc, junk_lo};
  endfunction

  function automatic int next_addr(input int a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    ref_addr = 0;
    ref_err  = 3'b000;
    for (int k = 0; k < WORDS; k++) ref_stage[k] = '0;
    exp_q.delete();
  endtask

  task automatic post_check();
    chk("addr_out", 128'(addr_out), 128'(ref_addr));
    chk("error_out", 128'(error_out), 128'(ref_err));
  endtask

  // driver tasks: all are entered and left #1 after a rising edge
  task automatic do_reset();
    rst_in = 1'b1;
    instr_valid_in = 1'b0;
    buffer_valid_in = 1'b0;
    abc_ready_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    chk("rst_instr_ready", 128'(instr_ready_out), 128'(1));
    chk("rst_idle", 128'(idle_out), 128'(1));
    chk("rst_buffer_ready", 128'(buffer_ready_out), 128'(0));
    chk("rst_abc_valid", 128'(abc_valid_out), 128'(0));
    chk("rst_addr", 128'(addr_out), 128'(0));
    chk("rst_error", 128'(error_out), 128'(0));
  endtask

  task automatic issue(input logic [IW-1:0] instr);
    int w;
    w = 0;
    instr_in = instr;
    instr_valid_in = 1'b1;
    while (!instr_ready_out && w < 50) begin
      @(posedge clk_in); #1;
      w++;
    end
    if (w == 50) chk("instr_ready_timeout", 128'(0), 128'(1));
    @(posedge clk_in); #1;
    instr_valid_in = 1'b0;
    instr_in = $urandom;
  endtask

  task automatic op_loadi(input int ra, input logic [15:0] v);
    issue(mk(OP_LOADI, ra[3:0], v, 1'($urandom_range(0, 1))));
    if (ra >= WORDS) ref_err[0] = 1'b1;
    else ref_stage[ra] = v[WORD_WIDTH-1:0];
    post_check();
  endtask

  task automatic op_sma(input int a);
    issue(mk(OP_SMA, 4'($urandom_range(0, 15)), a[15:0], 1'($urandom_range(0, 1))));
    if (a >= DEPTH) ref_err[2] = 1'b1;
    else ref_addr = a;
    post_check();
  endtask

  task automatic op_flush(input bit inc);
    logic [LW-1:0] line;
    issue(mk(OP_FLUSH, 4'd0, 16'd0, inc));
    line = '0;
    for (int k = 0; k < WORDS; k++) line[LW-1-k*WORD_WIDTH -: WORD_WIDTH] = ref_stage[k];
    ref_mem[ref_addr] = line;
    ref_written[ref_addr] = 1'b1;
    for (int k = 0; k < WORDS; k++) ref_stage[k] = '0;
    if (inc) ref_addr = next_addr(ref_addr);
    post_check();
  endtask

  task automatic op_loadb(input bit inc, input int dly, input logic [LW-1:0] line);
    issue(mk(OP_LOADB, 4'd0, 16'd0, inc));
    for (int i = 0; i < dly; i++) begin
      chk("loadb_wait_buffer_ready", 128'(buffer_ready_out), 128'(1));
      chk("loadb_wait_instr_ready", 128'(instr_ready_out), 128'(0));
      @(posedge clk_in); #1;
    end
    buffer_line_in = line;
    buffer_valid_in = 1'b1;
    chk("loadb_buffer_ready", 128'(buffer_ready_out), 128'(1));
    @(posedge clk_in); #1;
    buffer_valid_in = 1'b0;
    buffer_line_in = rand_line();
    ref_mem[ref_addr] = line;
    ref_written[ref_addr] = 1'b1;
    if (inc) ref_addr = next_addr(ref_addr);
    chk("loadb_done_buffer_ready", 128'(buffer_ready_out), 128'(0));
    chk("loadb_done_idle", 128'(idle_out), 128'(1));
    post_check();
  endtask

  task automatic op_writeb(input bit inc, input int hold);
    int lat;
    logic [LW-1:0] exp;
    abc_ready_in = (hold == 0);
    issue(mk(OP_WRITEB, 4'd0, 16'd0, inc));
    exp_q.push_back(ref_mem[ref_addr]);
    if (inc) ref_addr = next_addr(ref_addr);
    chk("writeb_not_idle", 128'(idle_out), 128'(0));
    lat = 0;
    while (!abc_valid_out && lat < 20) begin
      @(posedge clk_in); #1;
      lat++;
    end
    chk("writeb_latency", 128'(lat), 128'(BRAM_LATENCY));
    if (abc_valid_out && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("writeb_data", 128'(abc_out), 128'(exp));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_in); #1;
        chk("hold_valid", 128'(abc_valid_out), 128'(1));
        chk("hold_data", 128'(abc_out), 128'(exp));
      end
      abc_ready_in = 1'b1;
      @(posedge clk_in); #1;
      abc_ready_in = 1'b0;
      chk("writeb_valid_cleared", 128'(abc_valid_out), 128'(0));
      chk("writeb_idle_after", 128'(idle_out), 128'(1));
    end
    post_check();
  endtask

  task automatic op_bad(input logic [3:0] op);
    issue(mk(op, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1))));
    ref_err[1] = 1'b1;
    post_check();
  endtask

  function automatic logic [3:0] bad_opcode();
    logic [3:0] tbl [10];
    tbl = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB, 4'hD, 4'hF};
    return tbl[$urandom_range(0, 9)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line7;
    int r, a;
    rst_in = 1'b1;
    instr_in = '0;
    instr_valid_in = 1'b0;
    buffer_line_in = '0;
    buffer_valid_in = 1'b0;
    abc_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_written[i] = 1'b0;
    @(posedge clk_in); #1;
    do_reset();

    // full staging line to line 3, read back with immediate ready
    for (int k = 0; k < WORDS; k++) op_loadi(k, 16'(32'h1111 * (k + 1)));
    op_sma(3);
    op_flush(1'b0);
    op_writeb(1'b0, 0);
    chk("tp1_line3_model", 128'(ref_mem[3]), 128'(96'h111122223333444455556666));

    // delayed buffer line into line 7, then a held read of it
    op_sma(7);
    line7 = rand_line();
    op_loadb(1'b0, 5, line7);
    op_writeb(1'b0, 4);
    chk("tp2_line7_model", 128'(ref_mem[7]), 128'(line7));

    // address wrap on post-increment
    op_sma(DEPTH - 1);
    op_loadb(1'b1, 0, rand_line());
    op_loadb(1'b0, 1, rand_line());
    op_sma(DEPTH - 1);
    op_writeb(1'b1, 0);
    op_writeb(1'b1, 2);
    chk("wrap_addr", 128'(addr_out), 128'(1));

    // errors are sticky and side-effect free; partial flush zero-fills
    do_reset();
    op_sma(5);
    op_loadi(2, 16'h1234);
    op_loadi(2, 16'hBEEF);
    op_loadi(6, 16'hDEAD);
    op_sma(400);
    op_bad(4'hF);
    chk("err_all", 128'(error_out), 128'(3'b111));
    chk("err_addr_kept", 128'(addr_out), 128'(5));
    op_flush(1'b0);
    op_writeb(1'b0, 1);
    chk("partial_line_model", 128'(ref_mem[5]), 128'(96'h0000_0000_BEEF_0000_0000_0000));
    op_sma(7);
    op_writeb(1'b0, 0);

    // reset while a read is in flight
    do_reset();
    op_sma(3);
    issue(mk(OP_WRITEB, 4'd0, 16'd0, 1'b0));
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    chk("rst_rw_valid", 128'(abc_valid_out), 128'(0));
    chk("rst_rw_idle", 128'(idle_out), 128'(1));
    chk("rst_rw_addr", 128'(addr_out), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      chk("rst_rw_valid_stays", 128'(abc_valid_out), 128'(0));
    end
    op_sma(3);
    op_writeb(1'b0, 0);

    // reset coinciding with a buffer line must not write the BRAM
    op_sma(7);
    issue(mk(OP_LOADB, 4'd0, 16'd0, 1'b0));
    buffer_line_in = rand_line();
    buffer_valid_in = 1'b1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    buffer_valid_in = 1'b0;
    model_reset();
    chk("rst_wb_buffer_ready", 128'(buffer_ready_out), 128'(0));
    op_sma(7);
    op_writeb(1'b0, 0);

    // randomized instruction mix
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        op_loadi($urandom_range(0, 7), 16'($urandom));
      end else if (r < 40) begin
        a = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15)
          : (($urandom_range(0, 4) == 0) ? $urandom_range(DEPTH, DEPTH + 100)
                                         : $urandom_range(0, DEPTH - 1));
        op_sma(a);
      end else if (r < 52) begin
        op_flush(1'($urandom_range(0, 1)));
      end else if (r < 70) begin
        op_loadb(1'($urandom_range(0, 1)), $urandom_range(0, 4), rand_line());
      end else if (r < 92) begin
        if (ref_written[ref_addr]) op_writeb(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        else op_loadb(1'b0, $urandom_range(0, 2), rand_line());
      end else if (r < 97) begin
        issue(mk(OP_NOP, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1))));
        post_check();
      end else begin
        op_bad(bad_opcode());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
